layer_output_collector: RTL and testbench
=========================================

Name: layer_output_collector

Overview:
- Downstream stage of the inference top level. Consumes the final-layer neuron outputs that master_engine produces, one per handshake.
- Buffers the outputs, tracks the running signed maximum (argmax), and reports the classification result with done/busy status.
- Provides a registered readback port so a host or debug logic can read any buffered neuron output.

Parameters:
- DATA_W, 16, width of one neuron output (signed two's complement, same fixed-point format as wt_in/bias_in)
- MAX_N, 32, buffer depth = maximum neurons in the output layer
- IDX_W, 6, width of counts/indices; matches the 6-bit nl*/n/i fields

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle pulse: arm collection of a new output vector
- expected_n  input  IDX_W  number of outputs to collect; sampled on start
- in_valid  input  1  in_data valid this cycle
- in_data  input  DATA_W  signed neuron output
- in_ready  output  1  collector can accept; transfer = in_valid & in_ready
- rd_addr  input  IDX_W  buffer read address
- rd_data  output  DATA_W  buffer word at rd_addr, registered
- busy  output  1  high in COLLECT
- done  output  1  high in DONE until the next accepted start
- class_idx  output  IDX_W  index of the maximum output
- class_val  output  DATA_W  value of the maximum output
- count  output  IDX_W  outputs accepted so far
- err  output  1  sticky error flag; cleared only by reset or an accepted start

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; in_ready, busy, done, err = 0; count, class_idx = 0; class_val, rd_data = 0. Buffer contents are don't-care; reads return 0 until written in the current run.
- FSM states: IDLE, COLLECT, DONE.
- Accepted start in IDLE or DONE with 1 <= expected_n <= MAX_N:
  - latch expected_n; clear count, err, done, class_idx, class_val; set a first-sample flag
  - go to COLLECT next cycle
- start with expected_n = 0 or expected_n > MAX_N: set err = 1, go to or stay in IDLE, done = 0.
- start while in COLLECT: ignored. No restart, no error.
- COLLECT:
  - in_ready = 1, busy = 1.
  - On each transfer: buf[count] <= in_data; count <= count + 1.
  - Max update: if the first-sample flag is set, or in_data > class_val (signed, strict), then class_val <= in_data and class_idx <= count. Ties keep the lower index.
  - The transfer with count == expected_n-1 moves the FSM to DONE on the next cycle. done rises 1 cycle after the last transfer, and class_idx/class_val are valid in that same cycle.
- DONE:
  - in_ready = 0, busy = 0, done = 1.
  - in_valid = 1 while in DONE or IDLE sets err = 1 (overflow/unexpected data). Data is discarded.
- Readback:
  - rd_data <= (rd_addr < count) ? buf[rd_addr] : 0. One-cycle latency, available in all states.
  - Reads are concurrent with writes. Reading the address being written in the same cycle returns the old value (0 if not yet written this run).
- in_ready depends only on state; there is no combinational path from in_valid.
- Reset asserted mid-COLLECT: returns to IDLE next edge; all outputs at reset values; partial results discarded.
- Arithmetic: compare is full DATA_W signed. count never exceeds expected_n; no wrap.

Test Plan:
- Reset, then start with expected_n=4; stream 0x0010, 0xFFF0, 0x0100, 0x0080 back-to-back -> done 1 cycle after 4th transfer, class_idx=2, class_val=0x0100, count=4, err=0.
- All-negative vector, expected_n=3: 0xFF00, 0xFFFE, 0xFFFE -> class_idx=1, class_val=0xFFFE (tie keeps lower index), proving signed compare and first-sample load.
- Gapped in_valid (valid every 3rd cycle), expected_n=5 -> same result as back-to-back; then read addresses 0..5 -> 1-cycle latency data, rd_addr=5 returns 0.
- start with expected_n=0, then expected_n=33 -> err=1, FSM stays IDLE, in_ready=0, done=0; a following valid start with expected_n=2 clears err.
- After DONE, drive in_valid=1 with 0x7FFF -> in_ready=0, err=1, class_val unchanged; start pulse during COLLECT -> ignored, count continues.
- Assert rst_n=0 after 2 of 4 transfers -> next cycle busy=0, count=0, class_val=0; restart completes normally with a fresh vector.

Source files
------------

// File: rtl/layer_output_collector.sv
// layer_output_collector: buffers final-layer neuron outputs, tracks the signed argmax, offers registered readback
// Ports: start/expected_n arm a run; in_valid/in_data/in_ready stream outputs in;
// rd_addr/rd_data read the buffer one cycle later; busy/done/err/count/class_idx/class_val report status.
module layer_output_collector #(
  parameter int DATA_W = 16,
  parameter int MAX_N  = 32,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [IDX_W-1:0]  expected_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              busy,
  output logic              done,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] class_val,
  output logic [IDX_W-1:0]  count,
  output logic              err
);
  localparam int AW = (MAX_N > 1) ? $clog2(MAX_N) : 1;
  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] exp_q, exp_d, count_q, count_d, idx_q, idx_d;
  logic [DATA_W-1:0] val_q, val_d, rd_q;
  logic err_q, err_d, first_q, first_d;
  logic [DATA_W-1:0] buf_q [MAX_N];
  logic armable, n_ok, xfer, take;
  assign armable = start && state_q != COLLECT;
  assign n_ok = expected_n != '0 && expected_n <= IDX_W'(MAX_N);
  assign xfer = in_valid && state_q == COLLECT;
  // first_q forces the first sample in; strict compare keeps the lower index on ties
  assign take = first_q || $signed(in_data) > $signed(val_q);
  always_comb begin
    state_d = state_q;
    exp_d = exp_q;
    count_d = count_q;
    idx_d = idx_q;
    val_d = val_q;
    err_d = err_q;
    first_d = first_q;
    if (armable && n_ok) begin
      state_d = COLLECT;
      exp_d = expected_n;
      count_d = '0;
      idx_d = '0;
      val_d = '0;
      err_d = 1'b0;
      first_d = 1'b1;
    end else if (armable) begin
      state_d = IDLE;
      err_d = 1'b1;
    end else if (xfer) begin
      count_d = count_q + IDX_W'(1);
      first_d = 1'b0;
      idx_d = take ? count_q : idx_q;
      val_d = take ? in_data : val_q;
      state_d = (count_q == exp_q - IDX_W'(1)) ? DONE : COLLECT;
    end else if (in_valid) begin
      err_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      exp_q <= '0;
      count_q <= '0;
      idx_q <= '0;
      val_q <= '0;
      err_q <= 1'b0;
      first_q <= 1'b0;
      rd_q <= '0;
    end else begin
      state_q <= state_d;
      exp_q <= exp_d;
      count_q <= count_d;
      idx_q <= idx_d;
      val_q <= val_d;
      err_q <= err_d;
      first_q <= first_d;
      // count_q gates stale entries, so same-cycle writes read back as the old (zero) value
      rd_q <= (rd_addr < count_q) ? buf_q[rd_addr[AW-1:0]] : '0;
    end
  end
  always_ff @(posedge clk) begin
    if (xfer) buf_q[count_q[AW-1:0]] <= in_data;
  end
  assign in_ready = state_q == COLLECT;
  assign busy = state_q == COLLECT;
  assign done = state_q == DONE;
  assign count = count_q;
  assign class_idx = idx_q;
  assign class_val = val_q;
  assign err = err_q;
  assign rd_data = rd_q;
endmodule

// File: tb/tb_layer_output_collector.sv
// tb_layer_output_collector: randomized scoreboard bench for layer_output_collector
module tb_layer_output_collector;
  logic clk = 0, rst_n = 0, start = 0, in_valid = 0;
  logic [5:0] expected_n = 0, rd_addr = 0;
  logic [15:0] in_data = 0;
  logic in_ready, busy, done, err;
  logic [15:0] rd_data, class_val;
  logic [5:0] class_idx, count;
  int vectors = 0, miscompares = 0;
  typedef struct packed {
    logic [5:0]  idx;
    logic [15:0] val;
    logic [5:0]  cnt;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e, last_e;
  logic [15:0] vec[$];
  logic done_d = 0;

  layer_output_collector dut (
    .clk(clk), .rst_n(rst_n), .start(start), .expected_n(expected_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .class_idx(class_idx), .class_val(class_val), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: first position holding the largest signed value
  function automatic exp_t model();
    exp_t e;
    int best = 0;
    foreach (vec[i]) if ($signed(vec[i]) > $signed(vec[best])) best = i;
    e.idx = 6'(best);
    e.val = vec[best];
    e.cnt = 6'(vec.size());
    return e;
  endfunction

  always @(negedge clk) begin
    if (rst_n && done && !done_d) begin
      if (sb.size() == 0) check("unexpected_done", 1, 0);
      else begin
        mon_e = sb.pop_front();
        check("class_idx", class_idx, mon_e.idx);
        check("class_val", class_val, mon_e.val);
        check("count", count, mon_e.cnt);
        check("err_clear", err, 0);
      end
    end
    done_d = done;
  end

  task automatic run_vec(input int gap, input bit mid);
    exp_t e;
    e = model();
    sb.push_back(e);
    last_e = e;
    @(posedge clk); #1;
    start = 1; expected_n = 6'(vec.size());
    @(posedge clk); #1;
    start = 0;
    foreach (vec[i]) begin
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1; in_data = vec[i];
      if (mid && i == 1) begin start = 1; expected_n = 6'd1; end
      @(negedge clk); check("in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 0; start = 0;
    end
    @(negedge clk); check("done_latency", done, 1);
    #1 check("sb_drain", sb.size(), 0);
  endtask

  task automatic rd_back();
    for (int a = 0; a <= vec.size() && a < 64; a++) begin
      rd_addr = 6'(a);
      @(posedge clk);
      @(negedge clk);
      check("rd_data", rd_data, (a < vec.size()) ? 32'(vec[a]) : 32'd0);
    end
  endtask

  task automatic bad_start(input logic [5:0] n);
    @(posedge clk); #1;
    start = 1; expected_n = n;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    check("bad_err", err, 1);
    check("bad_ready", in_ready, 0);
    check("bad_done", done, 0);
    check("bad_busy", busy, 0);
  endtask

  task automatic rand_fill(input int n);
    logic [15:0] pick[4];
    pick[0] = 16'h8000; pick[1] = 16'hFFFF; pick[2] = 16'h0000; pick[3] = 16'h7FFF;
    vec.delete();
    for (int i = 0; i < n; i++)
      vec.push_back(($urandom_range(0, 3) == 0) ? pick[$urandom_range(0, 3)] : 16'($urandom));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_count", count, 0);
    check("rst_idx", class_idx, 0);
    check("rst_val", class_val, 0);
    check("rst_rd", rd_data, 0);
    @(posedge clk); #1 rst_n = 1;
    vec = '{16'h0010, 16'hFFF0, 16'h0100, 16'h0080};
    run_vec(0, 0);
    vec = '{16'hFF00, 16'hFFFE, 16'hFFFE};
    run_vec(0, 0);
    vec = '{16'h0123, 16'h8001, 16'h0456, 16'h0456, 16'hF000};
    run_vec(2, 0);
    rd_back();
    bad_start(6'd0);
    bad_start(6'd33);
    bad_start(6'd63);
    vec = '{16'h0005, 16'h0007};
    run_vec(0, 0);
    @(posedge clk); #1;
    in_valid = 1; in_data = 16'h7FFF;
    @(negedge clk); check("done_ready", in_ready, 0);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    check("ovf_err", err, 1);
    check("ovf_val", class_val, last_e.val);
    check("ovf_done", done, 1);
    rand_fill(6);
    run_vec(1, 1);
    rand_fill(4);
    @(posedge clk); #1;
    start = 1; expected_n = 6'd4;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1; in_data = vec[i];
      @(posedge clk); #1;
    end
    in_valid = 0; rst_n = 0;
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk);
    check("mid_busy", busy, 0);
    check("mid_count", count, 0);
    check("mid_val", class_val, 0);
    check("mid_idx", class_idx, 0);
    check("mid_done", done, 0);
    check("mid_ready", in_ready, 0);
    rand_fill(4);
    run_vec(0, 0);
    rand_fill(32);
    run_vec(0, 0);
    rd_back();
    rand_fill(1);
    run_vec(1, 0);
    rd_back();
    for (int k = 0; k < 20; k++) begin
      rand_fill($urandom_range(1, 32));
      run_vec($urandom_range(0, 2), $urandom_range(0, 1) == 1 && vec.size() > 2);
      if (k % 4 == 0) rd_back();
    end
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
